// File: rtl/seq_det_param.sv
// seq_det_param: serial N-bit pattern detector; i_b/i_en feed bits, i_load/i_pattern reload the pattern, i_overlap selects mode; o_w match pulse, o_match_count saturating count, o_debug fill level
module seq_det_param #(
  parameter int N = 4,
  parameter logic [N-1:0] PAT_INIT = 4'b1011,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_b,
  input  logic                   i_en,
  input  logic                   i_load,
  input  logic [N-1:0]           i_pattern,
  input  logic                   i_overlap,
  output logic                   o_w,
  output logic [CNT_W-1:0]       o_match_count,
  output logic [$clog2(N+1)-1:0] o_debug
);
  localparam int FW = $clog2(N+1);
  logic [N-1:0] r_pat, r_hist;
  logic [FW-1:0] r_fill;
  logic r_w;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0] w_cand;
  logic w_hit;
  assign w_cand = {r_hist[N-2:0], i_b};
  assign w_hit = (w_cand == r_pat) && (r_fill >= FW'(N - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pat <= PAT_INIT;
      r_hist <= '0;
      r_fill <= '0;
      r_w <= 1'b0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_pat <= i_pattern;
      r_hist <= '0;
      r_fill <= '0;
      r_w <= 1'b0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_hist <= w_cand;
      r_w <= w_hit;
      if (w_hit) begin
        r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        r_fill <= i_overlap ? FW'(N) : '0;
      end else
        r_fill <= (r_fill == FW'(N)) ? r_fill : r_fill + 1'b1;
    end else
      r_w <= 1'b0;
  assign o_w = r_w;
  assign o_match_count = r_cnt;
  assign o_debug = r_fill;
endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param: randomized and directed checks of seq_det_param against a queue-based model
module tb_seq_det_param;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_b = 1'b0, i_en = 1'b0, i_load = 1'b0, i_overlap = 1'b0;
  logic [N-1:0] i_pattern = '0;
  logic o_w, o_w_s;
  logic [7:0] o_cnt;
  logic [1:0] o_cnt_s;
  logic [2:0] o_dbg, o_dbg_s;
  int n_tot = 0, n_pass = 0, pulses = 0;
  bit q[$];
  int fresh, mcnt, mcnt_s;
  logic [N-1:0] mpat;
  logic mw;
  seq_det_param #(.N(N), .PAT_INIT(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .i_b(i_b), .i_en(i_en), .i_load(i_load), .i_pattern(i_pattern),
    .i_overlap(i_overlap), .o_w(o_w), .o_match_count(o_cnt), .o_debug(o_dbg));
  seq_det_param #(.N(N), .PAT_INIT(4'b1011), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .i_b(i_b), .i_en(i_en), .i_load(i_load), .i_pattern(i_pattern),
    .i_overlap(i_overlap), .o_w(o_w_s), .o_match_count(o_cnt_s), .o_debug(o_dbg_s));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  always @(posedge clk or posedge rst) begin
    bit hit;
    if (rst) begin
      q.delete(); fresh = 0; mpat = 4'b1011; mcnt = 0; mcnt_s = 0; mw = 0;
    end else if (i_load) begin
      q.delete(); fresh = 0; mpat = i_pattern; mcnt = 0; mcnt_s = 0; mw = 0;
    end else if (i_en) begin
      q.push_back(i_b);
      if (q.size() > N) void'(q.pop_front());
      hit = (q.size() == N) && (fresh >= N - 1);
      for (int i = 0; i < q.size(); i++) if (q[i] != mpat[N-1-i]) hit = 0;
      mw = hit;
      if (hit) begin
        mcnt = (mcnt < 255) ? mcnt + 1 : 255;
        mcnt_s = (mcnt_s < 3) ? mcnt_s + 1 : 3;
        fresh = i_overlap ? N : 0;
      end else fresh = (fresh < N) ? fresh + 1 : N;
    end else mw = 0;
  end
  always @(negedge clk) if (!rst) begin
    chk("w", o_w, mw);
    chk("w_s", o_w_s, mw);
    chk("count", o_cnt, mcnt);
    chk("count_s", o_cnt_s, mcnt_s);
    chk("debug", o_dbg, fresh);
    chk("debug_s", o_dbg_s, fresh);
    if (o_w) pulses++;
  end
  task automatic drive(input logic b, input logic en, input logic ld, input logic [N-1:0] p, input logic ov);
    i_b = b; i_en = en; i_load = ld; i_pattern = p; i_overlap = ov;
    @(negedge clk);
  endtask
  task automatic bits(input logic [15:0] v, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) drive(v[i], 1'b1, 1'b0, '0, ov);
  endtask
  task automatic load(input logic [N-1:0] p);
    drive(1'b0, 1'b0, 1'b1, p, 1'b0);
  endtask
  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask
  initial begin
    int p0;
    logic [N-1:0] pats [4] = '{4'b1011, 4'b0110, 4'b1111, 4'b0000};
    @(negedge clk);
    repeat (3) drive(~i_b, 1'b1, 1'b0, '0, 1'b1);
    chk("rst_w", o_w, 0);
    chk("rst_count", o_cnt, 0);
    chk("rst_debug", o_dbg, 0);
    rst = 1'b0;
    p0 = pulses; bits(16'b1011, 4, 1'b1); idle();
    chk("init_pulses", pulses - p0, 1);
    chk("init_count", o_cnt, 1);
    load(4'b1011);
    p0 = pulses; bits(16'b1011011, 7, 1'b1); idle();
    chk("ovl_pulses", pulses - p0, 2);
    chk("ovl_count", o_cnt, 2);
    load(4'b1011);
    p0 = pulses; bits(16'b1011011, 7, 1'b0); idle();
    chk("novl_pulses", pulses - p0, 1);
    chk("novl_count", o_cnt, 1);
    load(4'b1011);
    p0 = pulses; bits(16'b10, 2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 1'b0, 1'b0, '0, 1'b1);
      if (i == 2) chk("gap_debug", o_dbg, 2);
    end
    bits(16'b11, 2, 1'b1); idle();
    chk("gap_pulses", pulses - p0, 1);
    bits(16'b101, 3, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1);
    chk("ld_debug", o_dbg, 0);
    chk("ld_count", o_cnt, 0);
    p0 = pulses; bits(16'b0110, 4, 1'b1); idle();
    chk("ld_pulses", pulses - p0, 1);
    load(4'b1111);
    p0 = pulses; bits(16'hFF, 8, 1'b1); idle();
    chk("sat_pulses", pulses - p0, 5);
    chk("sat_count_s", o_cnt_s, 3);
    chk("sat_count", o_cnt, 5);
    load(4'b1011);
    bits(16'b101, 3, 1'b1);
    #2 rst = 1'b1;
    #1 chk("arst_debug", o_dbg, 0);
    chk("arst_w", o_w, 0);
    @(negedge clk);
    rst = 1'b0;
    p0 = pulses; bits(16'b1, 1, 1'b1); idle();
    chk("arst_pulses", pulses - p0, 0);
    for (int i = 0; i < 600; i++) begin
      logic ld;
      ld = ($urandom_range(0, 39) == 0);
      drive(1'($urandom), ($urandom_range(0, 3) != 0), ld,
            ($urandom_range(0, 4) == 4) ? N'($urandom) : pats[$urandom_range(0, 3)], 1'($urandom));
    end
    idle();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial bit-sequence detector and the successor of the fixed 3-bit-state `SeqDet`. It samples one serial bit per enabled clock and compares the last `N` bits against a run-time loadable pattern. It pulses `w` on every match and keeps a saturating match count. Overlapping or non-overlapping detection is selected at run time, and the block sits directly behind the switch/debounce input path on the lab board.

## Interface
- `N`, 4, pattern length in bits, 2..16
- `PAT_INIT`, 4'b1011, pattern held after reset, N bits wide
- `CNT_W`, 8, width of `match_count`
- `clk`  in  1  single clock; all state changes on its rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `b`  in  1  serial data bit, sampled only when `en`=1
- `en`  in  1  bit-valid qualifier
- `load`  in  1  latch `pattern` into the internal pattern register
- `pattern`  in  N  new pattern; MSB is the first bit received
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping
- `w`  out  1  registered match pulse
- `match_count`  out  CNT_W  saturating count of matches
- `debug`  out  $clog2(N+1)  current fill count, for LEDs

## Operation
- Internal state: `pat_reg[N-1:0]`, history shift register `hist[N-1:0]`, and fill counter `fill` (0..N).
- Reset (async, immediate) sets these values:
  - `pat_reg`=`PAT_INIT`
  - `hist`=0
  - `fill`=0
  - `w`=0
  - `match_count`=0
  - `debug`=0
- On `load`=1:
  - `pat_reg`<=`pattern`, `hist`<=0, `fill`<=0, `match_count`<=0, `w`<=0.
  - Any `b` sampled in the same cycle is discarded, so `load` takes priority over `en`.
- On `en`=1 and `load`=0:
  - `cand` = {hist[N-2:0], b}, and `hist`<=`cand`.
  - The match condition is `cand`==`pat_reg` AND `fill`>=N-1, i.e. N valid bits including this one.
- If the condition holds:
  - `w`<=1.
  - `match_count`<=`match_count`+1, saturating at 2^CNT_W-1.
  - `fill`<=N when `overlap`=1; `fill`<=0 when `overlap`=0, so the next match needs N fresh bits.
- If the condition does not hold: `w`<=0 and `fill`<=min(`fill`+1, N).
- On `en`=0 and `load`=0: all state holds and `w`<=0.
- `overlap` is sampled on every enabled bit. Changing it mid-stream affects only the handling of the next match.
- `debug` = `fill`.

## Timing
- The bit is sampled on rising edge k, and `w` is high for exactly the cycle following edge k. The pulse is one clock wide even if `en` stays high.
- `match_count` updates on the same edge as `w` rises.
- Back-to-back matches under overlap can hold `w` high on consecutive cycles, one pulse per match. For example, pattern 1111 with a continuous stream of ones.
- A pattern loaded at edge k is used for bits sampled at edge k+1 onward.
- `rst` asserted mid-sequence clears `w` and `fill` combinationally-asynchronously. A partial sequence is never completed across reset.
- `en` gaps do not break a sequence: held bits stay in history.
- No combinational path from inputs to outputs.

## Test plan
- Reset/defaults: with `rst`=1 and `b`=1 toggling, `w`=0, `match_count`=0, `debug`=0. After release, stream 1,0,1,1 with `en`=1 gives `w`=1 for one cycle after the 4th edge and `match_count`=1.
- Overlap: N=4, pattern 1011, `overlap`=1, stream 1,0,1,1,0,1,1 gives `w` pulses after bits 4 and 7 and `match_count`=2. The same stream with `overlap`=0 gives a pulse after bit 4 only and `match_count`=1.
- `en` gating: pattern 1011, bits 1,0 then `en`=0 for 5 cycles with `b` toggling, then 1,1 gives one pulse after the final bit, and `debug` holds at 2 during the gap.
- Load priority and reload: after 3 bits, assert `load` with `pattern`=0110 and `en`=1 in the same cycle. Result: `debug`=0 and `match_count`=0. Stream 0,1,1,0 then gives one pulse.
- Saturation: CNT_W=2, pattern 1111, `overlap`=1, eight ones gives 5 pulses (bits 4..8), and `match_count` stops at 3.
- Async reset mid-operation: after bits 1,0,1 assert `rst` mid-cycle. `debug` goes to 0 before the next edge. After release, a single 1 gives no pulse.
